// File: rtl/tcd_dma_mc_if.sv
// Memory-read and NoC flit-egress signal bundle for the multi-channel DMA engine.
// The master side is the engine; the slave side is the memory and NI.
interface tcd_dma_mc_if #(
    parameter int unsigned MEMORY_BUS_WIDTH = 32,
    parameter int unsigned FLIT_WIDTH       = 16
) ();
    localparam int unsigned AW = MEMORY_BUS_WIDTH - 2;

    logic                        mem_rd_out;
    logic [AW-1:0]               mem_addr_out;
    logic [MEMORY_BUS_WIDTH-1:0] mem_data_in;
    logic                        mem_valid_in;
    logic [FLIT_WIDTH-1:0]       flit_out;
    logic                        flit_valid_out;
    logic                        flit_ready_in;

    modport master (
        output mem_rd_out, mem_addr_out, flit_out, flit_valid_out,
        input  mem_data_in, mem_valid_in, flit_ready_in
    );

    modport slave (
        input  mem_rd_out, mem_addr_out, flit_out, flit_valid_out,
        output mem_data_in, mem_valid_in, flit_ready_in
    );
endinterface

// File: rtl/tcd_dma_mc.sv
// Multi-channel transfer-control DMA: per-channel request latching, round-robin
// arbitration, word-by-word memory reads serialised LS-flit-first toward the NI.
module tcd_dma_mc #(
    parameter int unsigned MEMORY_BUS_WIDTH = 32,
    parameter int unsigned FLIT_WIDTH       = 16,
    parameter int unsigned NUM_CHANNELS     = 4,
    localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int unsigned AW   = MEMORY_BUS_WIDTH - 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CHANNELS-1:0]    req_in,
    input  logic [NUM_CHANNELS*AW-1:0] addr_in,
    input  logic [NUM_CHANNELS*AW-1:0] nbytes_in,
    input  logic [NUM_CHANNELS-1:0]    ack_in,
    output logic [NUM_CHANNELS-1:0]    irq_out,
    output logic [NUM_CHANNELS-1:0]    busy_out,
    output logic [CH_W-1:0]            chan_out,
    tcd_dma_mc_if.master               bus
);
    localparam int unsigned FB    = FLIT_WIDTH / 8;
    localparam int unsigned FPW   = MEMORY_BUS_WIDTH / FLIT_WIDTH;
    localparam int unsigned FPW_W = (FPW > 1) ? $clog2(FPW) : 1;
    localparam int unsigned FL_W  = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [NUM_CHANNELS-1:0]     r_busy;
    logic [NUM_CHANNELS-1:0]     r_irq;
    logic [AW-1:0]               r_addr   [NUM_CHANNELS];
    logic [AW-1:0]               r_nbytes [NUM_CHANNELS];
    logic [CH_W-1:0]             r_last;
    logic [CH_W-1:0]             r_chan;
    logic [AW-1:0]               r_cur_addr;
    logic [FL_W-1:0]             r_flits_left;
    logic [FPW_W-1:0]            r_fpw_cnt;
    logic [MEMORY_BUS_WIDTH-1:0] r_word;
    logic                        r_mem_rd;
    logic                        r_flit_valid;

    logic                        w_gnt_vld;
    logic [CH_W-1:0]             w_gnt_ch;
    logic [FL_W-1:0]             w_gnt_flits;
    logic                        w_word_done;
    logic                        w_flit_acc;

    // Round-robin pick: scan downward so the channel nearest after r_last wins last.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        for (int unsigned k = NUM_CHANNELS; k >= 1; k--) begin
            idx = (32'(r_last) + k) % NUM_CHANNELS;
            if (r_busy[CH_W'(idx)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        w_gnt_flits = (FL_W'(r_nbytes[w_gnt_ch]) + FL_W'(FB - 1)) / FL_W'(FB);
        w_word_done = (r_fpw_cnt == FPW_W'(FPW - 1)) || (r_flits_left == FL_W'(1));
        w_flit_acc  = r_flit_valid && bus.flit_ready_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_state_nxt = (w_gnt_flits == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.mem_valid_in) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_flit_acc && w_word_done) begin
                    w_state_nxt = (r_flits_left == FL_W'(1)) ? S_DONE : S_READ;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Transfer datapath; strobe and flit-valid are registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_rd     <= 1'b0;
            r_flit_valid <= 1'b0;
            r_chan       <= '0;
            r_last       <= CH_W'(NUM_CHANNELS - 1);
            r_cur_addr   <= '0;
            r_flits_left <= '0;
            r_fpw_cnt    <= '0;
            r_word       <= '0;
        end else begin
            r_mem_rd     <= (w_state_nxt == S_READ);
            r_flit_valid <= (w_state_nxt == S_SEND);
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_chan       <= w_gnt_ch;
                        r_last       <= w_gnt_ch;
                        r_cur_addr   <= r_addr[w_gnt_ch];
                        r_flits_left <= w_gnt_flits;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_valid_in) begin
                        r_word    <= bus.mem_data_in;
                        r_fpw_cnt <= '0;
                    end
                end
                S_SEND: begin
                    if (w_flit_acc) begin
                        r_word       <= r_word >> FLIT_WIDTH;
                        r_flits_left <= r_flits_left - FL_W'(1);
                        r_fpw_cnt    <= r_fpw_cnt + FPW_W'(1);
                        if (w_word_done) begin
                            r_cur_addr <= r_cur_addr + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-channel request latch, busy and sticky IRQ; a channel re-latches only once its IRQ is acked.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
            r_irq  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_addr[i]   <= '0;
                r_nbytes[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if ((r_state == S_DONE) && (r_chan == CH_W'(i))) begin
                    r_busy[i] <= 1'b0;
                    r_irq[i]  <= 1'b1;
                end else if (req_in[i] && !r_busy[i] && !r_irq[i]) begin
                    r_busy[i]   <= 1'b1;
                    r_addr[i]   <= addr_in[i*AW +: AW];
                    r_nbytes[i] <= nbytes_in[i*AW +: AW];
                end
                if (ack_in[i] && r_irq[i]) begin
                    r_irq[i] <= 1'b0;
                end
            end
        end
    end

    assign irq_out            = r_irq;
    assign busy_out           = r_busy;
    assign chan_out           = r_chan;
    assign bus.mem_rd_out     = r_mem_rd;
    assign bus.mem_addr_out   = r_cur_addr;
    assign bus.flit_out       = r_word[FLIT_WIDTH-1:0];
    assign bus.flit_valid_out = r_flit_valid;

endmodule
